// File: rtl/ct_merge_arb_if.sv
// Streaming merge link bundle: NI input streams in, one registered stream out.
// Signal names are seen from the merge node's side (slave modport).
interface ct_merge_arb_if #(
   parameter int NI = 2,
   parameter int WO = 8
);
   logic [NI*WO-1:0] i_data;
   logic [NI-1:0]    i_valid;
   logic [NI-1:0]    o_ready;
   logic [WO-1:0]    o_data;
   logic             o_valid;
   logic             i_ready;

   modport slave  (input  i_data, i_valid, i_ready, output o_ready, o_data, o_valid);
   modport master (output i_data, i_valid, i_ready, input  o_ready, o_data, o_valid);
endinterface

// File: rtl/ct_merge_arb.sv
// Packet-aware round-robin merge: one input owns the output link from its first
// beat through its EOP beat; accepted beats land in a single output register.
module ct_merge_arb #(
   parameter int NI      = 2,
   parameter int WO      = 8,
   parameter int EOP_LOC = 0
) (
   input  logic          clk,
   input  logic          reset,
   ct_merge_arb_if.slave bus
);
   localparam int LW = (NI > 1) ? $clog2(NI) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state, state_nxt;
   logic [LW-1:0]          last, last_nxt, grant, grant_nxt;
   logic [LW-1:0]          win, idx, sel;
   logic                   found, can_load, xfer, eop;
   logic [NI-1:0][WO-1:0]  lane_data;
   logic [WO-1:0]          beat;
   logic [NI-1:0]          ready;

   assign lane_data = bus.i_data;
   assign can_load  = !bus.o_valid || bus.i_ready;

   // Rotating-priority search starting just after the last served input.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int j = 1; j <= NI; j++) begin
         idx = LW'((int'(last) + j) % NI);
         if (!found && bus.i_valid[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign sel  = (state == LOCKED) ? grant : win;
   assign beat = lane_data[sel];
   assign eop  = beat[EOP_LOC];

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      grant_nxt = grant;
      ready     = '0;
      xfer      = 1'b0;
      unique case (state)
         IDLE: begin
            if (can_load && found) begin
               ready[win] = 1'b1;
               xfer       = 1'b1;
               if (eop) begin
                  last_nxt = win;
               end else begin
                  state_nxt = LOCKED;
                  grant_nxt = win;
               end
            end
         end
         LOCKED: begin
            // Grant is held across bubbles; nobody else is served until EOP.
            ready[grant] = can_load;
            xfer         = can_load && bus.i_valid[grant];
            if (xfer && eop) begin
               state_nxt = IDLE;
               last_nxt  = grant;
            end
         end
         default: ;
      endcase
   end

   assign bus.o_ready = reset ? ready : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         last  <= LW'(NI - 1);
         grant <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         grant <= grant_nxt;
      end
   end

   // Output stage: o_data keeps its value on a load without a beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.o_valid <= 1'b0;
         bus.o_data  <= '0;
      end else if (can_load) begin
         bus.o_valid <= xfer;
         if (xfer) bus.o_data <= beat;
      end
   end
endmodule

// File: tb/tb_ct_merge_arb.sv
// Bench for ct_merge_arb (NI=3, 9-bit beats with EOP on bit 8): directed
// scenarios with literal expectations plus a randomized run against a model.
module tb_ct_merge_arb;
   localparam int NI      = 3;
   localparam int WO      = 9;
   localparam int EOP_LOC = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   ct_merge_arb_if #(.NI(NI), .WO(WO)) bus ();

   ct_merge_arb #(.NI(NI), .WO(WO), .EOP_LOC(EOP_LOC)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   logic [NI-1:0][WO-1:0] lanes = '0;
   logic [NI-1:0]         vld   = '0;
   logic                  rdy   = 1'b1;
   assign bus.i_data  = lanes;
   assign bus.i_valid = vld;
   assign bus.i_ready = rdy;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: owner = input holding the link (-1 none), lst = last served input.
   int               m_owner = -1;
   int               m_last  = NI - 1;
   logic             m_ov    = 1'b0;
   logic [WO-1:0]    m_od    = '0;
   logic [NI-1:0]    exp_rdy, m_fire;
   int               m_k;

   function automatic logic [NI-1:0] model_ready(input logic rst_n, input int owner, input int lst,
                                                 input logic ov, input logic ir, input logic [NI-1:0] v);
      int i;
      if (!rst_n || (ov && !ir)) return '0;
      if (owner >= 0) return NI'(1) << owner;
      for (int j = 1; j <= NI; j++) begin
         i = (lst + j) % NI;
         if (v[i[1:0]]) return NI'(1) << i;
      end
      return '0;
   endfunction

   always_comb begin
      exp_rdy = model_ready(reset, m_owner, m_last, m_ov, rdy, vld);
      m_fire  = exp_rdy & vld;
      m_k     = 0;
      for (int k = 0; k < NI; k++) if (m_fire[k]) m_k = k;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_owner <= -1;
         m_last  <= NI - 1;
         m_ov    <= 1'b0;
         m_od    <= '0;
      end else if (!m_ov || rdy) begin
         m_ov <= (m_fire != '0);
         if (m_fire != '0) begin
            m_od <= lanes[m_k[1:0]];
            if (lanes[m_k[1:0]][EOP_LOC]) begin
               m_owner <= -1;
               m_last  <= m_k;
            end else begin
               m_owner <= m_k;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("o_ready", 32'(bus.o_ready), 32'(exp_rdy));
      chk("o_valid", 32'(bus.o_valid), 32'(m_ov));
      chk("o_data",  32'(bus.o_data),  32'(m_od));
   end

   logic [7:0] outq[$];
   always @(posedge clk) if (reset && bus.o_valid && bus.i_ready) outq.push_back(bus.o_data[7:0]);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic v, input logic e, input logic [7:0] b);
      vld[k]   = v;
      lanes[k] = {e, b};
   endtask

   task automatic do_reset();
      reset = 1'b0;
      vld   = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   logic [NI-1:0] fired;
   logic [7:0]    exp_rr[9];

   initial begin
      // Reset and first beat
      tick(); tick(); tick();
      chk("rst_o_valid", 32'(bus.o_valid), 0);
      chk("rst_o_data",  32'(bus.o_data),  0);
      chk("rst_o_ready", 32'(bus.o_ready), 0);
      reset = 1'b1;
      drive(0, 1, 1, 8'h11);
      #1 chk("first_o_ready", 32'(bus.o_ready), 32'h1);
      tick();
      drive(0, 0, 0, 8'h00);
      chk("first_o_valid", 32'(bus.o_valid), 1);
      chk("first_o_data",  32'(bus.o_data),  32'h111);

      // Round-robin with single-beat packets, no gaps
      do_reset();
      outq.delete();
      for (int k = 0; k < NI; k++) drive(k, 1, 1, 8'hA0 + 8'(k));
      for (int c = 0; c < 9; c++) tick();
      vld = '0;
      tick(); tick();
      exp_rr = '{8'hA0, 8'hA1, 8'hA2, 8'hA0, 8'hA1, 8'hA2, 8'hA0, 8'hA1, 8'hA2};
      chk("rr_count", 32'(outq.size()), 9);
      for (int i = 0; i < 9 && i < outq.size(); i++) chk("rr_order", 32'(outq[i]), 32'(exp_rr[i]));

      // Packet lock on input 1 while input 0 keeps requesting
      do_reset();
      outq.delete();
      drive(0, 1, 1, 8'h01);
      tick();
      drive(1, 1, 0, 8'h21);
      #1 chk("lock_rdy_b1", 32'(bus.o_ready), 32'h2);
      tick();
      drive(1, 1, 0, 8'h22);
      #1 chk("lock_rdy_b2", 32'(bus.o_ready), 32'h2);
      tick();
      drive(1, 1, 1, 8'h23);
      #1 chk("lock_rdy_b3", 32'(bus.o_ready), 32'h2);
      tick();
      drive(1, 0, 0, 8'h00);
      #1 chk("lock_rdy_after", 32'(bus.o_ready), 32'h1);
      tick();
      drive(0, 0, 0, 8'h00);
      tick(); tick();
      chk("lock_count", 32'(outq.size()), 5);
      if (outq.size() == 5) begin
         chk("lock_seq0", 32'(outq[0]), 32'h01);
         chk("lock_seq1", 32'(outq[1]), 32'h21);
         chk("lock_seq2", 32'(outq[2]), 32'h22);
         chk("lock_seq3", 32'(outq[3]), 32'h23);
         chk("lock_seq4", 32'(outq[4]), 32'h01);
      end

      // Backpressure hold
      drive(1, 1, 1, 8'h5A);
      tick();
      outq.delete();
      rdy = 1'b0;
      drive(1, 0, 0, 8'h00);
      drive(2, 1, 1, 8'h5B);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("bp_o_ready", 32'(bus.o_ready), 0);
         chk("bp_o_data",  32'(bus.o_data),  32'h15A);
         chk("bp_o_valid", 32'(bus.o_valid), 1);
         tick();
      end
      rdy = 1'b1;
      #1 chk("bp_release_rdy", 32'(bus.o_ready), 32'h4);
      tick();
      drive(2, 0, 0, 8'h00);
      tick(); tick();
      chk("bp_count", 32'(outq.size()), 2);
      if (outq.size() == 2) begin
         chk("bp_seq0", 32'(outq[0]), 32'h5A);
         chk("bp_seq1", 32'(outq[1]), 32'h5B);
      end

      // Bubble inside a locked packet on input 2
      do_reset();
      drive(1, 1, 1, 8'h0F);
      tick();
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 1, 8'h01);
      drive(2, 1, 0, 8'h31);
      #1 chk("bub_rdy0", 32'(bus.o_ready), 32'h4);
      tick();
      chk("bub_d31", 32'(bus.o_data), 32'h031);
      drive(2, 0, 0, 8'h00);
      for (int c = 0; c < 2; c++) begin
         #1 chk("bub_rdy_hold", 32'(bus.o_ready), 32'h4);
         tick();
         chk("bub_o_valid", 32'(bus.o_valid), 0);
      end
      drive(2, 1, 1, 8'h32);
      #1 chk("bub_rdy_eop", 32'(bus.o_ready), 32'h4);
      tick();
      chk("bub_d32", 32'(bus.o_data), 32'h132);
      drive(2, 0, 0, 8'h00);
      #1 chk("bub_rdy_next", 32'(bus.o_ready), 32'h1);
      tick();
      chk("bub_d01", 32'(bus.o_data), 32'h101);
      drive(0, 0, 0, 8'h00);
      tick();

      // Asynchronous reset in the middle of a locked packet
      drive(1, 1, 0, 8'h41);
      tick();
      chk("mid_d41", 32'(bus.o_data), 32'h041);
      #2 reset = 1'b0;
      #1;
      chk("mid_o_valid", 32'(bus.o_valid), 0);
      chk("mid_o_data",  32'(bus.o_data),  0);
      chk("mid_o_ready", 32'(bus.o_ready), 0);
      tick();
      reset = 1'b1;
      drive(0, 1, 1, 8'h51);
      drive(1, 1, 1, 8'h42);
      #1 chk("mid_rdy_after", 32'(bus.o_ready), 32'h1);
      tick();
      chk("mid_d51", 32'(bus.o_data), 32'h151);
      vld = '0;
      tick();

      // Randomized traffic: senders hold a beat until it is accepted
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NI; k++)
            if (!vld[k] && ($urandom_range(1, 0) == 1))
               drive(k, 1, ($urandom_range(2, 0) == 0), 8'($urandom));
         rdy = ($urandom_range(3, 0) != 0);
         #1 fired = bus.o_ready & vld;
         tick();
         vld = vld & ~fired;
      end
      rdy = 1'b1;
      vld = '0;
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
